// File: rtl/stereo_cap_pkg.sv
// stereo_cap_pkg: shared types, widths and pixel quantiser.
// QUANT_ROUND_EN selects rounding instead of truncation.
package stereo_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACTIVE,
    DONE
  } state_e;

  localparam int PIX_W    = 3;
  localparam int ADDR_W   = 16;
  localparam int FB_DEPTH = 100 * 100;

  function automatic logic [PIX_W-1:0] quant(
    input logic [7:0] pix
  );
`ifdef QUANT_ROUND_EN
    logic [8:0] s;
    s = {1'b0, pix} + 9'd16;
    // s >= 256 means the rounded value is 8: clamp
    quant = s[8] ? 3'd7 : s[7:5];
`else
    quant = pix[7:5];
`endif
  endfunction

endpackage

// File: rtl/edge_det.sv
// edge_det: registered history, rise/fall of d_i vs last cycle.
// Ports: clk, rst_n, d_i in; rise_o, fall_o out.
module edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= RST_VAL;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/stereo_cap_writer.sv
// stereo_cap_writer: crops a camera frame into left/right buffers.
// In: vclk, rst_n, cam_vs/href/pvalid/pix, eye_sel.
// Out: wraddr/wrdata/wren l+r, frame_done, frame_err, busy.
// QUANT_ROUND_EN: round pixel data instead of truncating.
module stereo_cap_writer
  import stereo_cap_pkg::*;
#(
  parameter int SRC_W   = 320,
  parameter int SRC_H   = 240,
  parameter int CROP_X0 = 110,
  parameter int CROP_Y0 = 70,
  parameter int IMG_W   = 100,
  parameter int IMG_H   = 100
) (
  input  logic              vclk,
  input  logic              rst_n,
  input  logic              cam_vs,
  input  logic              cam_href,
  input  logic              cam_pvalid,
  input  logic [7:0]        cam_pix,
  input  logic              eye_sel,
  output logic [ADDR_W-1:0] wraddrl,
  output logic [PIX_W-1:0]  wrdatal,
  output logic              wrenl,
  output logic [ADDR_W-1:0] wraddrr,
  output logic [PIX_W-1:0]  wrdatar,
  output logic              wrenr,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int XW = $clog2(SRC_W + 1);
  localparam int YW = $clog2(SRC_H + 1);

  localparam logic [XW-1:0] X_MAX = XW'(SRC_W);
  localparam logic [XW-1:0] X_LO  = XW'(CROP_X0);
  localparam logic [XW-1:0] X_HI  = XW'(CROP_X0 + IMG_W);
  localparam logic [YW-1:0] Y_MAX = YW'(SRC_H);
  localparam logic [YW-1:0] Y_LO  = YW'(CROP_Y0);
  localparam logic [YW-1:0] Y_HI  = YW'(CROP_Y0 + IMG_H);

  localparam logic [ADDR_W-1:0] W_LAST =
    ADDR_W'(IMG_W * IMG_H - 1);

  logic vs_rise, vs_fall;
  logic href_fall, href_rise_unused;

  edge_det #(.RST_VAL(1'b1)) u_vs (
    .clk    (vclk),
    .rst_n  (rst_n),
    .d_i    (cam_vs),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  edge_det #(.RST_VAL(1'b0)) u_href (
    .clk    (vclk),
    .rst_n  (rst_n),
    .d_i    (cam_href),
    .rise_o (href_rise_unused),
    .fall_o (href_fall)
  );

  state_e            state_q;
  logic              eye_q;
  logic              pend_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] wcnt_q;
  logic [ADDR_W-1:0] addrl_q, addrr_q;
  logic [PIX_W-1:0]  datal_q, datar_q;
  logic              wenl_q, wenr_q;
  logic              done_q, err_q;

  logic             accept, in_crop, wr, last;
  logic [PIX_W-1:0] pix_d;

  assign accept  = cam_href & cam_pvalid;
  assign in_crop = (x_q >= X_LO) && (x_q < X_HI) &&
                   (y_q >= Y_LO) && (y_q < Y_HI);
  assign wr      = (state_q == ACTIVE) && accept && in_crop;
  assign last    = wr && (wcnt_q == W_LAST);
  assign pix_d   = quant(cam_pix);

  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      eye_q   <= 1'b0;
      pend_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      wcnt_q  <= '0;
      addrl_q <= '0;
      addrr_q <= '0;
      datal_q <= '0;
      datar_q <= '0;
      wenl_q  <= 1'b0;
      wenr_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wenl_q <= 1'b0;
      wenr_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (wr) begin
        if (eye_q) begin
          wenr_q  <= 1'b1;
          addrr_q <= wcnt_q;
          datar_q <= pix_d;
        end else begin
          wenl_q  <= 1'b1;
          addrl_q <= wcnt_q;
          datal_q <= pix_d;
        end
        wcnt_q <= wcnt_q + ADDR_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (vs_rise) state_q <= SYNC;
        end
        SYNC: begin
          if (vs_fall) begin
            state_q <= ACTIVE;
            eye_q   <= eye_sel;
            x_q     <= '0;
            y_q     <= '0;
            wcnt_q  <= '0;
          end
        end
        ACTIVE: begin
          if (accept && x_q != X_MAX)
            x_q <= x_q + XW'(1);
          if (href_fall) begin
            x_q <= '0;
            if (y_q != Y_MAX) y_q <= y_q + YW'(1);
          end
          // completion wins over a coincident vsync rise
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pend_q  <= vs_rise;
          end else if (vs_rise) begin
            state_q <= SYNC;
            err_q   <= 1'b1;
            wcnt_q  <= '0;
          end
        end
        DONE: begin
          state_q <= (pend_q || vs_rise) ? SYNC : IDLE;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wraddrl    = addrl_q;
  assign wrdatal    = datal_q;
  assign wrenl      = wenl_q;
  assign wraddrr    = addrr_q;
  assign wrdatar    = datar_q;
  assign wrenr      = wenr_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q == SYNC) || (state_q == ACTIVE);

endmodule

// File: tb/tb_stereo_cap_writer.sv
// tb_stereo_cap_writer: directed frames, scoreboard of writes.
// Honours QUANT_ROUND_EN for expected pixel data.
module tb_stereo_cap_writer;

  localparam int CX = 110;
  localparam int CY = 70;
  localparam int IW = 100;
  localparam int IH = 100;
  localparam int NPIX = IW * IH;

  logic        vclk = 1'b0;
  logic        rst_n;
  logic        cam_vs, cam_href, cam_pvalid;
  logic [7:0]  cam_pix;
  logic        eye_sel;
  logic [15:0] wraddrl, wraddrr;
  logic [2:0]  wrdatal, wrdatar;
  logic        wrenl, wrenr;
  logic        frame_done, frame_err, busy;

  always #5 vclk = ~vclk;

  stereo_cap_writer dut (
    .vclk       (vclk),
    .rst_n      (rst_n),
    .cam_vs     (cam_vs),
    .cam_href   (cam_href),
    .cam_pvalid (cam_pvalid),
    .cam_pix    (cam_pix),
    .eye_sel    (eye_sel),
    .wraddrl    (wraddrl),
    .wrdatal    (wrdatal),
    .wrenl      (wrenl),
    .wraddrr    (wraddrr),
    .wrdatar    (wrdatar),
    .wrenr      (wrenr),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    logic        eye;
    logic [15:0] addr;
    logic [2:0]  data;
    int          cyc;
  } wr_t;

  wr_t sbq[$];
  wr_t em;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  int done_n = 0;
  int err_n  = 0;
  int wr_n   = 0;
  int wc     = 0;

  logic [15:0] pal = '0, par = '0;
  logic [2:0]  pdl = '0, pdr = '0;

  logic [7:0] sp_pix [3] = '{8'hF0, 8'h10, 8'h0F};
`ifdef QUANT_ROUND_EN
  logic [2:0] sp_exp [3] = '{3'd7, 3'd1, 3'd0};
`else
  logic [2:0] sp_exp [3] = '{3'd7, 3'd0, 3'd0};
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [7:0] p);
    int v;
`ifdef QUANT_ROUND_EN
    v = (int'(p) + 16) / 32;
    if (v > 7) v = 7;
`else
    v = int'(p) / 32;
`endif
    return 3'(v);
  endfunction

  always @(posedge vclk) cyc++;

  always @(negedge vclk) begin
    if (wrenl || wrenr) begin
      wr_n++;
      if (sbq.size() == 0) begin
        chk("spurious_wr", 32'({wrenr, wrenl}), 32'd0);
      end else begin
        em = sbq.pop_front();
        chk("wr_en", 32'({wrenr, wrenl}),
            em.eye ? 32'd2 : 32'd1);
        chk("wr_addr", 32'(em.eye ? wraddrr : wraddrl),
            32'(em.addr));
        chk("wr_data", 32'(em.eye ? wrdatar : wrdatal),
            32'(em.data));
        chk("wr_cyc", cyc, em.cyc);
        if (!wrenr)
          chk("hold_r", 32'({wraddrr, wrdatar}),
              32'({par, pdr}));
        if (!wrenl)
          chk("hold_l", 32'({wraddrl, wrdatal}),
              32'({pal, pdl}));
      end
    end
    if (frame_done) begin
      done_n++;
      chk("done_drain", sbq.size(), 0);
    end
    if (frame_err) err_n++;
    pal = wraddrl;
    pdl = wrdatal;
    par = wraddrr;
    pdr = wrdatar;
  end

  task automatic tick();
    @(negedge vclk);
  endtask

  task automatic px(input logic [7:0] p, input int x,
                    input int y, input logic tgt,
                    input bit frc, input logic [2:0] fd);
    wr_t e;
    cam_href   = 1'b1;
    cam_pvalid = 1'b1;
    cam_pix    = p;
    if (x >= CX && x < CX + IW && y >= CY && y < CY + IH) begin
      e.eye  = tgt;
      e.addr = 16'(wc);
      e.data = frc ? fd : model(p);
      e.cyc  = cyc + 1;
      sbq.push_back(e);
      wc++;
    end
    tick();
  endtask

  task automatic frame(input logic eye, input int last_y,
                       input bit alt, input bit tog,
                       input bit vs_last, input int stop_wc,
                       input bit special);
    bit         stop;
    bit         frc;
    logic [2:0] fd;
    logic [7:0] p;
    stop = 0;
    cam_vs = 1'b1;
    repeat (3) tick();
    eye_sel = eye;
    cam_vs  = 1'b0;
    tick();
    tick();
    chk("busy_active", 32'(busy), 32'd1);
    wc = 0;
    for (int y = 0; y <= last_y && !stop; y++) begin
      if (y < CY) begin
        cam_href   = 1'b1;
        cam_pvalid = 1'b0;
        tick();
      end else begin
        for (int x = 0; x <= CX + IW && !stop; x++) begin
          if (alt && x >= CX && x < CX + IW) begin
            cam_href   = 1'b1;
            cam_pvalid = 1'b0;
            cam_pix    = 8'hAA;
            tick();
          end
          if (tog) eye_sel = ~eye_sel;
          p   = 8'((x + y) & 255);
          frc = 0;
          fd  = '0;
          if (special && y == CY && x >= CX && wc < 3) begin
            p   = sp_pix[wc];
            frc = 1;
            fd  = sp_exp[wc];
          end
          if (vs_last && wc == NPIX - 1 &&
              x >= CX && x < CX + IW)
            cam_vs = 1'b1;
          px(p, x, y, eye, frc, fd);
          if (stop_wc > 0 && wc == stop_wc) stop = 1;
        end
      end
      if (!stop) begin
        cam_href   = 1'b0;
        cam_pvalid = 1'b0;
        tick();
      end
    end
  endtask

  initial begin
    int base;
    rst_n      = 1'b0;
    cam_vs     = 1'b0;
    cam_href   = 1'b0;
    cam_pvalid = 1'b0;
    cam_pix    = '0;
    eye_sel    = 1'b0;
    repeat (3) tick();
    chk("rst_wraddrl", 32'(wraddrl), 32'd0);
    chk("rst_wrdatal", 32'(wrdatal), 32'd0);
    chk("rst_wrenl", 32'(wrenl), 32'd0);
    chk("rst_wraddrr", 32'(wraddrr), 32'd0);
    chk("rst_wrdatar", 32'(wrdatar), 32'd0);
    chk("rst_wrenr", 32'(wrenr), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // A: left eye, vsync rises with the final write
    base = wr_n;
    frame(1'b0, CY + IH - 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20 && done_n < 1; i++) tick();
    repeat (3) tick();
    chk("A_done", done_n, 1);
    chk("A_err", err_n, 0);
    chk("A_wr_count", wr_n - base, NPIX);
    chk("A_sync_busy", 32'(busy), 32'd1);
    chk("A_drain", sbq.size(), 0);

    // B: aborted after line 120
    base = wr_n;
    frame(1'b0, 120, 0, 0, 0, 0, 0);
    cam_vs = 1'b1;
    for (int i = 0; i < 20 && err_n < 1; i++) tick();
    tick();
    chk("B_err", err_n, 1);
    chk("B_done", done_n, 1);
    chk("B_wr_count", wr_n - base, (121 - CY) * IW);
    chk("B_sync_busy", 32'(busy), 32'd1);
    chk("B_drain", sbq.size(), 0);

    // C: right eye, eye_sel toggling, pvalid gaps
    base = wr_n;
    frame(1'b1, CY + IH - 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 20 && done_n < 2; i++) tick();
    repeat (3) tick();
    chk("C_done", done_n, 2);
    chk("C_err", err_n, 1);
    chk("C_wr_count", wr_n - base, NPIX);
    chk("C_idle_busy", 32'(busy), 32'd0);
    chk("C_drain", sbq.size(), 0);

    // D: reset after 5000 writes
    base = wr_n;
    eye_sel = 1'b0;
    frame(1'b0, CY + IH - 1, 0, 0, 0, 5000, 0);
    cam_pvalid = 1'b0;
    tick();
    chk("D_wr_count", wr_n - base, 5000);
    chk("D_pre_addr", 32'(wraddrl), 32'd4999);
    rst_n    = 1'b0;
    cam_vs   = 1'b0;
    cam_href = 1'b0;
    #1;
    chk("D_rst_wrenl", 32'(wrenl), 32'd0);
    chk("D_rst_addrl", 32'(wraddrl), 32'd0);
    chk("D_rst_datal", 32'(wrdatal), 32'd0);
    chk("D_rst_addrr", 32'(wraddrr), 32'd0);
    chk("D_rst_datar", 32'(wrdatar), 32'd0);
    chk("D_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("D_no_err", err_n, 1);
    chk("D_drain", sbq.size(), 0);

    // E: fresh frame after reset, quantiser corner pixels
    base = wr_n;
    frame(1'b0, CY, 0, 0, 0, 3, 1);
    cam_pvalid = 1'b0;
    cam_href   = 1'b0;
    repeat (3) tick();
    chk("E_wr_count", wr_n - base, 3);
    chk("E_drain", sbq.size(), 0);
    chk("E_done", done_n, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/stereo_cap_writer.md
STEREO_CAP_WRITER -- requirements
Module: stereo_cap_writer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SRC_W, 320, source active pixels per line.
- SRC_H, 240, source active lines per frame.
- CROP_X0, 110, first captured column.
- CROP_Y0, 70, first captured line.
- IMG_W, 100, crop width.
- IMG_H, 100, crop height.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- vclk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cam_vs  in  1  frame sync, high between frames.
- cam_href  in  1  line active.
- cam_pvalid  in  1  pixel qualifier, valid only while cam_href=1.
- cam_pix  in  8  grayscale pixel.
- eye_sel  in  1  0=left buffer, 1=right buffer.
- wraddrl  out  16  left buffer write address.
- wrdatal  out  3  left buffer write data.
- wrenl  out  1  left buffer write enable.
- wraddrr  out  16  right buffer write address.
- wrdatar  out  3  right buffer write data.
- wrenr  out  1  right buffer write enable.
- frame_done  out  1  one-cycle pulse when a full crop has been written.
- frame_err  out  1  one-cycle pulse when a frame aborts early.
- busy  out  1  high in SYNC and ACTIVE.

Function
REQ-003 FSM states SHALL be IDLE, SYNC, ACTIVE and DONE; the rising edge of cam_vs SHALL move IDLE to SYNC.
REQ-004 The falling edge of cam_vs SHALL move SYNC to ACTIVE, latch eye_sel into the target-eye register, and clear the x counter, y counter and write counter.
REQ-005 In ACTIVE, x SHALL increment per cycle with cam_href&cam_pvalid, saturating at SRC_W; the falling edge of cam_href SHALL clear x and increment y, saturating at SRC_H.
REQ-006 A pixel SHALL be written only when CROP_X0<=x<CROP_X0+IMG_W and CROP_Y0<=y<CROP_Y0+IMG_H.
REQ-007 The write address SHALL be the 16-bit write counter, running 0..IMG_W*IMG_H-1 and incrementing once per written pixel.
REQ-008 Latency SHALL be one cycle: a pixel accepted at cycle N SHALL present address, data and write enable at N+1.
REQ-009 Only the target eye's write enable SHALL assert; the other eye's address and data SHALL hold their previous values.
REQ-010 Write data SHALL be cam_pix[7:5] unless QUANT_ROUND_EN is defined (see REQ-016).
REQ-011 When the write counter reaches IMG_W*IMG_H, the FSM SHALL enter DONE, pulse frame_done for one cycle, and return to IDLE on the next cycle.
REQ-012 If cam_vs rises in ACTIVE before completion, frame_err SHALL pulse one cycle and the FSM SHALL go to SYNC; partial data SHALL remain in the buffer and the address SHALL restart at 0.
REQ-013 A cam_vs rise in the same cycle as the final write SHALL complete the frame (frame_done pulses, no frame_err), and the FSM SHALL then enter SYNC rather than IDLE.
REQ-014 Changes to eye_sel outside the SYNC-to-ACTIVE transition SHALL have no effect.

Reset
REQ-015 When rst_n=0, the FSM SHALL be IDLE, all counters 0, all addresses 0, all data 0, wrenl=wrenr=0, frame_done=frame_err=busy=0, edge-detector history 1 for cam_vs and 0 for cam_href; reset mid-frame SHALL abandon the frame without a frame_err pulse.

Configuration
REQ-016 When QUANT_ROUND_EN is defined, data SHALL be min(7,(cam_pix+16)>>5) computed in 9 bits; when it is undefined, truncation SHALL apply and no adder SHALL be present.

Structure
REQ-017 The package stereo_cap_pkg SHALL hold the FSM state enum, PIX_W=3, ADDR_W=16 and FB_DEPTH=IMG_W*IMG_H (10000).
REQ-018 One sub-module, edge_det (registered rise/fall detector), SHALL be instantiated for each of cam_vs and cam_href.

Verification
REQ-019 Full 320x240 frame with ramp pixel=(x+y)&0xFF and eye_sel=0: wrenl asserts exactly 10000 times at addresses 0..9999, first data=(110+70)>>5=5, wrenr is never asserted, and frame_done pulses once.
REQ-020 eye_sel=1 at the cam_vs fall, toggled mid-frame: all writes go to the right buffer.
REQ-021 cam_vs rises after line 120: frame_err pulses, the next frame starts again at address 0, and frame_done pulses at its end.
REQ-022 cam_pvalid=0 on alternate cycles: the write count is still 10000 and addresses are contiguous.
REQ-023 With QUANT_ROUND_EN, pixels 0xF0, 0x10 and 0x0F give data 7, 1 and 0; without it they give 7, 0 and 0.
REQ-024 rst_n pulsed low at write 5000: outputs reach reset values immediately, and the next frame writes from address 0.
